// File: rtl/alu_branch_resolver_pkg.sv
// Shared definitions for the ALU branch resolver and the decode-stage static
// predictor: condition codes, flag-bit positions and the resolver FSM states.
package alu_pkg;

    // Condition codes carried on br_cond
    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_SIGN   = 3'd1;
    localparam logic [2:0] COND_ZERO   = 3'd2;
    localparam logic [2:0] COND_NZERO  = 3'd3;
    localparam logic [2:0] COND_CARRY  = 3'd4;
    localparam logic [2:0] COND_NCARRY = 3'd5;
    localparam logic [2:0] COND_GTZ    = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    // Bit positions inside the {sign,carry,zero} flags vector
    localparam int SIGN_B  = 2;
    localparam int CARRY_B = 1;
    localparam int ZERO_B  = 0;

    // Resolver control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    // Codes whose outcome does not depend on the flags never wait for an ALU op
    function automatic logic cond_is_flag_free(input logic [2:0] cond);
        return (cond == COND_ALWAYS) || (cond == COND_NEVER);
    endfunction

endpackage

// File: rtl/alu_branch_resolver_if.sv
// ALU-side and branch-side signals of the resolver, bundled as one bus.
// The master modport is the datapath/control side; the slave modport is the
// resolver itself.
interface alu_branch_resolver_if #(
    parameter int WIDTH = 32
) ();

    logic             alu_issue;
    logic             alu_valid;
    logic [WIDTH-1:0] result;
    logic             sign;
    logic             carry;
    logic             zero;
    logic             br_valid;
    logic             br_ready;
    logic [2:0]       br_cond;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] pc_next;
    logic             npc_valid;
    logic [WIDTH-1:0] npc;
    logic             taken;
    logic [2:0]       flags_q;

    modport master (
        output alu_issue, alu_valid, result, sign, carry, zero,
        output br_valid, br_cond, br_target, pc_next,
        input  br_ready, npc_valid, npc, taken, flags_q
    );

    modport slave (
        input  alu_issue, alu_valid, result, sign, carry, zero,
        input  br_valid, br_cond, br_target, pc_next,
        output br_ready, npc_valid, npc, taken, flags_q
    );

endinterface

// File: rtl/alu_branch_resolver_branch_cond_eval.sv
// Purely combinational condition evaluator: decides whether a branch with the
// given condition code is taken under the given {sign,carry,zero} flags.
// Also used by the decode stage's static predictor.
module branch_cond_eval
    import alu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       take
);

    // Map the condition code onto the flag bits
    always_comb begin
        take = 1'b0;
        case (cond)
            COND_ALWAYS: take = 1'b1;
            COND_SIGN:   take = flags[SIGN_B];
            COND_ZERO:   take = flags[ZERO_B];
            COND_NZERO:  take = !flags[ZERO_B];
            COND_CARRY:  take = flags[CARRY_B];
            COND_NCARRY: take = !flags[CARRY_B];
            COND_GTZ:    take = !flags[SIGN_B] && !flags[ZERO_B];
            COND_NEVER:  take = 1'b0;
            default:     take = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_branch_resolver.sv
// ALU branch resolver: holds the architectural flags, tracks one in-flight
// flag-setting ALU op and resolves conditional branches into the next PC.
// A branch that needs flags while an op is in flight either waits for the
// result or, if the result arrives in the accepting cycle, uses it directly.
// Optional build macro ALU_BRANCH_RESOLVER_STATS_EN adds saturating
// taken / not-taken counters.
module alu_branch_resolver
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_branch_resolver_if.slave bus
`ifdef ALU_BRANCH_RESOLVER_STATS_EN
    ,
    output logic [STAT_W-1:0]   taken_cnt,
    output logic [STAT_W-1:0]   not_taken_cnt
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic             pending_q;
    logic [2:0]       flags_r;
    logic [2:0]       cond_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] npc_r;
    logic             taken_r;

    logic [2:0]       in_flags;
    logic             accept;
    logic [2:0]       eval_cond;
    logic [2:0]       eval_flags;
    logic [WIDTH-1:0] eval_target;
    logic [WIDTH-1:0] eval_fall;
    logic             eval_take;
    logic             load_res;
    logic             latch_req;

    // The zero flag is recomputed from the result so a bad ALU zero output
    // can never steer a branch; the incoming zero bit is deliberately unused.
    assign in_flags = {bus.sign, bus.carry, (bus.result == '0)};
    assign accept   = bus.br_valid && (state_q == IDLE);

    branch_cond_eval u_eval (
        .cond  (eval_cond),
        .flags (eval_flags),
        .take  (eval_take)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, plus selection of which condition/flags/addresses to resolve with
    always_comb begin
        state_d     = state_q;
        eval_cond   = bus.br_cond;
        eval_flags  = flags_r;
        eval_target = bus.br_target;
        eval_fall   = bus.pc_next;
        load_res    = 1'b0;
        latch_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    latch_req = 1'b1;
                    if (cond_is_flag_free(bus.br_cond) || !pending_q) begin
                        load_res = 1'b1;
                        state_d  = RESOLVE;
                    end else if (bus.alu_valid) begin
                        eval_flags = in_flags;
                        load_res   = 1'b1;
                        state_d    = RESOLVE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                eval_cond   = cond_q;
                eval_flags  = in_flags;
                eval_target = target_q;
                eval_fall   = fall_q;
                if (bus.alu_valid) begin
                    load_res = 1'b1;
                    state_d  = RESOLVE;
                end
            end
            RESOLVE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flags, in-flight tracking, latched request and resolved outcome
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r   <= '0;
            pending_q <= 1'b0;
            cond_q    <= '0;
            target_q  <= '0;
            fall_q    <= '0;
            npc_r     <= '0;
            taken_r   <= 1'b0;
        end else begin
            if (bus.alu_valid) flags_r <= in_flags;
            pending_q <= bus.alu_issue || (pending_q && !bus.alu_valid);
            if (latch_req) begin
                cond_q   <= bus.br_cond;
                target_q <= bus.br_target;
                fall_q   <= bus.pc_next;
            end
            if (load_res) begin
                taken_r <= eval_take;
                npc_r   <= eval_take ? eval_target : eval_fall;
            end
        end
    end

`ifdef ALU_BRANCH_RESOLVER_STATS_EN
    // Saturating outcome counters, bumped once per resolved branch
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (state_q == RESOLVE) begin
            if (taken_r) begin
                if (taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
            end else begin
                if (not_taken_cnt != '1) not_taken_cnt <= not_taken_cnt + 1'b1;
            end
        end
    end
`endif

    assign bus.br_ready  = (state_q == IDLE);
    assign bus.npc_valid = (state_q == RESOLVE);
    assign bus.npc       = npc_r;
    assign bus.taken     = taken_r;
    assign bus.flags_q   = flags_r;

endmodule

// File: tb/tb_alu_branch_resolver.sv
// Self-checking bench for alu_branch_resolver: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
// With ALU_BRANCH_RESOLVER_STATS_EN defined the counters are checked too.
module tb_alu_branch_resolver;

    localparam int WIDTH   = 32;
    localparam int STAT_W  = 2;
    localparam int STATMAX = (1 << STAT_W) - 1;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_branch_resolver_if #(.WIDTH(WIDTH)) bus ();

`ifdef ALU_BRANCH_RESOLVER_STATS_EN
    logic [STAT_W-1:0] taken_cnt;
    logic [STAT_W-1:0] not_taken_cnt;
`endif

    alu_branch_resolver #(.WIDTH(WIDTH), .STAT_W(STAT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus)
`ifdef ALU_BRANCH_RESOLVER_STATS_EN
        ,
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt)
`endif
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state
    logic [2:0]  m_flags;
    bit          m_pending;
    bit          m_hold;
    logic [2:0]  m_cond;
    logic [31:0] m_tgt;
    logic [31:0] m_pc;
    bit          m_npc_valid;
    bit          m_taken;
    logic [31:0] m_npc;
    int          m_tc;
    int          m_ntc;

    function automatic bit cond_take(input logic [2:0] c, input logic [2:0] f);
        bit s, cy, z;
        s  = f[2];
        cy = f[1];
        z  = f[0];
        case (c)
            3'd0: return 1'b1;
            3'd1: return s;
            3'd2: return z;
            3'd3: return !z;
            3'd4: return cy;
            3'd5: return !cy;
            3'd6: return !s && !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic resolve(input logic [2:0] c, input logic [2:0] f,
                           input logic [31:0] tg, input logic [31:0] pn);
        m_npc_valid = 1'b1;
        m_taken     = cond_take(c, f);
        m_npc       = m_taken ? tg : pn;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and step past the clock edge
    task automatic applyStimulus(input bit r, input bit ai, input bit av,
                                 input logic [31:0] res, input bit s, input bit cy, input bit z,
                                 input bit bv, input logic [2:0] cd,
                                 input logic [31:0] tg, input logic [31:0] pn);
        logic [2:0] inf;
        bit was_res, was_taken, idle;
        rst           = r;
        bus.alu_issue = ai;
        bus.alu_valid = av;
        bus.result    = res;
        bus.sign      = s;
        bus.carry     = cy;
        bus.zero      = z;
        bus.br_valid  = bv;
        bus.br_cond   = cd;
        bus.br_target = tg;
        bus.pc_next   = pn;

        inf       = {s, cy, (res == 32'd0)};
        was_res   = m_npc_valid;
        was_taken = m_taken;
        idle      = !m_hold && !m_npc_valid;
        m_npc_valid = 1'b0;
        if (r) begin
            m_flags = 3'd0; m_pending = 0; m_hold = 0;
            m_taken = 0; m_npc = 32'd0; m_tc = 0; m_ntc = 0;
        end else begin
            if (was_res) begin
                if (was_taken) m_tc  = (m_tc  == STATMAX) ? STATMAX : m_tc + 1;
                else           m_ntc = (m_ntc == STATMAX) ? STATMAX : m_ntc + 1;
            end
            if (bv && idle) begin
                if (cd == 3'd0 || cd == 3'd7 || !m_pending) resolve(cd, m_flags, tg, pn);
                else if (av) resolve(cd, inf, tg, pn);
                else begin
                    m_hold = 1; m_cond = cd; m_tgt = tg; m_pc = pn;
                end
            end else if (m_hold && av) begin
                resolve(m_cond, inf, m_tgt, m_pc);
                m_hold = 0;
            end
            if (av) m_flags = inf;
            m_pending = ai ? 1'b1 : (av ? 1'b0 : m_pending);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleStep();
        applyStimulus(0, 0, 0, 32'h1, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0);
    endtask

    // Compare every visible output with the model
    task automatic checkOutput(input string tag);
        chk({tag, ".br_ready"},  {31'd0, bus.br_ready},  {31'd0, (!m_hold && !m_npc_valid)});
        chk({tag, ".npc_valid"}, {31'd0, bus.npc_valid}, {31'd0, m_npc_valid});
        chk({tag, ".flags_q"},   {29'd0, bus.flags_q},   {29'd0, m_flags});
        chk({tag, ".taken"},     {31'd0, bus.taken},     {31'd0, m_taken});
        chk({tag, ".npc"},       bus.npc,                m_npc);
`ifdef ALU_BRANCH_RESOLVER_STATS_EN
        chk({tag, ".taken_cnt"},     32'(taken_cnt),     32'(m_tc));
        chk({tag, ".not_taken_cnt"}, 32'(not_taken_cnt), 32'(m_ntc));
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_flags = 0; m_pending = 0; m_hold = 0; m_cond = 0; m_tgt = 0; m_pc = 0;
        m_npc_valid = 0; m_taken = 0; m_npc = 0; m_tc = 0; m_ntc = 0;
        rst = 1'b1;
        bus.alu_issue = 0; bus.alu_valid = 0; bus.result = 0; bus.sign = 0;
        bus.carry = 0; bus.zero = 0; bus.br_valid = 0; bus.br_cond = 0;
        bus.br_target = 0; bus.pc_next = 0;
        @(posedge clk);
        #1;

        // Reset state
        applyStimulus(1, 0, 0, 32'h0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0);
        checkOutput("reset");
        chk("reset.ready_const", {31'd0, bus.br_ready}, 32'd1);

        // Reset while a branch waits for flags
        applyStimulus(0, 1, 0, 32'h5, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0);
        applyStimulus(0, 0, 0, 32'h5, 0, 0, 0, 1, 3'd2, 32'h200, 32'h10);
        checkOutput("rstwait.wait");
        applyStimulus(1, 0, 0, 32'h5, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0);
        checkOutput("rstwait.rst");
        applyStimulus(0, 0, 1, 32'h0, 1, 1, 1, 0, 3'd0, 32'd0, 32'd0);
        checkOutput("rstwait.av");
        idleStep();
        checkOutput("rstwait.after");
        chk("rstwait.no_npc", {31'd0, bus.npc_valid}, 32'd0);

        // Zero branch on already-settled flags
        applyStimulus(0, 0, 1, 32'h0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0);
        applyStimulus(0, 0, 0, 32'h7, 0, 0, 0, 1, 3'd2, 32'h100, 32'h44);
        checkOutput("zerobr");
        chk("zerobr.npc_const", bus.npc, 32'h100);
        idleStep();
        checkOutput("zerobr.hold");

        // Branch waits for the in-flight op's flags
        applyStimulus(0, 1, 0, 32'h9, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0);
        idleStep();
        applyStimulus(0, 0, 0, 32'h9, 0, 0, 0, 1, 3'd1, 32'h300, 32'h50);
        checkOutput("wait.w1");
        idleStep();
        checkOutput("wait.w2");
        idleStep();
        checkOutput("wait.w3");
        chk("wait.ready_low", {31'd0, bus.br_ready}, 32'd0);
        applyStimulus(0, 0, 1, 32'h8000_0000, 1, 0, 0, 0, 3'd0, 32'd0, 32'd0);
        checkOutput("wait.res");
        chk("wait.taken_const", {31'd0, bus.taken}, 32'd1);

        // Bypass: flags arrive in the accepting cycle
        applyStimulus(0, 1, 0, 32'h9, 0, 1, 0, 0, 3'd0, 32'd0, 32'd0);
        applyStimulus(0, 0, 1, 32'h12, 0, 0, 0, 1, 3'd4, 32'h99, 32'h20);
        checkOutput("bypass");
        chk("bypass.npc_const", bus.npc, 32'h20);

        // Zero flag recomputed from the result
        applyStimulus(0, 0, 1, 32'h3B9A_CA00, 0, 0, 1, 0, 3'd0, 32'd0, 32'd0);
        applyStimulus(0, 0, 0, 32'h1, 0, 0, 0, 1, 3'd3, 32'h80, 32'h4);
        checkOutput("zchk");
        chk("zchk.npc_const", bus.npc, 32'h80);

        // Five unconditional branches (counters saturate when enabled)
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 32'h1, 0, 0, 0, 1, 3'd0, 32'h400 + i, 32'h8);
            checkOutput("always.acc");
            idleStep();
        end
        checkOutput("always.end");

        // Never-branch while an op is in flight resolves immediately
        applyStimulus(0, 1, 0, 32'h1, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0);
        applyStimulus(0, 0, 0, 32'h1, 0, 0, 0, 1, 3'd7, 32'h500, 32'h60);
        checkOutput("never");
        applyStimulus(0, 0, 1, 32'h0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0);
        checkOutput("never.clr");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] res;
            res = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 2) == 0),
                          res, 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 3'($urandom), $urandom, $urandom);
            checkOutput("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
